// File: rtl/fb_pkg.sv
// fb_pkg: shared geometry, widths, fill FSM encoding and the pixel address helper
package fb_pkg;
    localparam int VIRT_W = 160;
    localparam int VIRT_H = 120;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 24;
    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} fill_state_t;
    // y*160 built as y*128 + y*32 so the row offset needs no multiplier
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/fb_rect_walker.sv
// fb_rect_walker: row-major x/y iterator producing frame-buffer addresses for a clipped rectangle
module fb_rect_walker import fb_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [7:0]        x0,
    input  logic [7:0]        x1,
    input  logic [6:0]        y0,
    input  logic [6:0]        y1,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [7:0]        cx;
    logic [6:0]        cy;
    logic [ADDR_W-1:0] row_base;
    always_ff @(posedge clk) begin
        if (rst) begin
            cx       <= '0;
            cy       <= '0;
            row_base <= '0;
        end else if (load) begin
            cx       <= x0;
            cy       <= y0;
            row_base <= xy_to_addr(8'd0, y0);
        end else if (advance) begin
            cx       <= (cx == x1) ? x0 : cx + 8'd1;
            cy       <= (cx == x1) ? cy + 7'd1 : cy;
            row_base <= (cx == x1) ? row_base + ADDR_W'(VIRT_W) : row_base;
        end
    end
    always_comb begin
        addr = row_base + ADDR_W'(cx);
        last = (cx == x1) && (cy == y1);
    end
endmodule

// File: rtl/frame_buf_fill_ctrl.sv
// frame_buf_fill_ctrl: rectangle fill sequencer sharing the frame-buffer write port with a
// single-pixel requester that has priority but can win at most every other cycle
module frame_buf_fill_ctrl import fb_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        x0,
    input  logic [7:0]        x1,
    input  logic [6:0]        y0,
    input  logic [6:0]        y1,
    input  logic [DATA_W-1:0] color,
    output logic              busy,
    output logic              done,
    input  logic              px_req,
    input  logic [ADDR_W-1:0] px_addr,
    input  logic [DATA_W-1:0] px_data,
    output logic              px_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en
);
    localparam logic [7:0] X_MAX = 8'(VIRT_W - 1);
    localparam logic [6:0] Y_MAX = 7'(VIRT_H - 1);
    fill_state_t       state;
    logic [7:0]        lx0, lx1, x1c;
    logic [6:0]        ly0, ly1, y1c;
    logic [DATA_W-1:0] lcolor;
    logic              empty, pix_win, fill_wr, walk_last;
    logic [ADDR_W-1:0] walk_addr;
    // x0 beyond the right edge always exceeds the clamped x1, same for y, so two compares suffice
    always_comb begin
        x1c     = (lx1 > X_MAX) ? X_MAX : lx1;
        y1c     = (ly1 > Y_MAX) ? Y_MAX : ly1;
        empty   = (lx0 > x1c) || (ly0 > y1c);
        pix_win = px_req && !px_ack;
        fill_wr = (state == FILL) && !pix_win;
    end
    fb_rect_walker u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    ((state == CLIP) && !empty),
        .advance (fill_wr),
        .x0      (lx0),
        .x1      (lx1),
        .y0      (ly0),
        .y1      (ly1),
        .addr    (walk_addr),
        .last    (walk_last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lx0     <= '0;
            lx1     <= '0;
            ly0     <= '0;
            ly1     <= '0;
            lcolor  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            px_ack  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            px_ack  <= pix_win;
            wr_en   <= pix_win || fill_wr;
            wr_addr <= pix_win ? px_addr : fill_wr ? walk_addr : wr_addr;
            wr_data <= pix_win ? px_data : fill_wr ? lcolor : wr_data;
            case (state)
                IDLE: if (start) begin
                    lx0    <= x0;
                    lx1    <= x1;
                    ly0    <= y0;
                    ly1    <= y1;
                    lcolor <= color;
                    busy   <= 1'b1;
                    state  <= CLIP;
                end
                CLIP: begin
                    lx1   <= x1c;
                    ly1   <= y1c;
                    busy  <= !empty;
                    done  <= empty;
                    state <= empty ? DONE : FILL;
                end
                FILL: if (fill_wr && walk_last) state <= DONE;
                // after a fill the done pulse trails the last write by one cycle
                DONE: begin
                    busy  <= 1'b0;
                    done  <= !done;
                    state <= done ? IDLE : DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_buf_fill_ctrl.sv
// tb_frame_buf_fill_ctrl: vector table, randomized fills with pixel traffic and hand-written corner sequences
module tb_frame_buf_fill_ctrl;
    logic        clk = 0, rst = 1, start = 0;
    logic [7:0]  x0 = 0, x1 = 0;
    logic [6:0]  y0 = 0, y1 = 0;
    logic [23:0] color = 0;
    logic        busy, done, px_ack, wr_en;
    logic        px_req = 0;
    logic [14:0] px_addr = 0, wr_addr;
    logic [23:0] px_data = 0, wr_data;

    frame_buf_fill_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .color(color), .busy(busy), .done(done), .px_req(px_req), .px_addr(px_addr),
        .px_data(px_data), .px_ack(px_ack), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, last_s = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          c;
        logic        ack, exp, en;
        logic [14:0] a, ea;
        logic [23:0] d, ed;
    } px_ev_t;

    logic        rec = 0, p_req = 0, last_ack = 0;
    logic [14:0] p_addr = 0;
    logic [23:0] p_data = 0;
    int          fa[$], fc[$], pc[$], dq[$];
    logic [23:0] fd[$];
    px_ev_t      pq[$];
    int          bn = 0;

    always @(posedge clk) begin
        p_req  <= px_req && !rst;
        p_addr <= px_addr;
        p_data <= px_data;
    end

    // outputs are stable at the falling edge; p_* hold the pixel inputs seen by the last rising edge
    always @(negedge clk) begin
        if (rec) begin
            if (px_ack || (p_req && !last_ack))
                pq.push_back('{cyc, px_ack, p_req && !last_ack, wr_en, wr_addr, p_addr, wr_data, p_data});
            if (px_ack) pc.push_back(cyc);
            else if (wr_en) begin
                fa.push_back(int'(wr_addr));
                fd.push_back(wr_data);
                fc.push_back(cyc);
            end
            if (done) dq.push_back(cyc);
            if (busy) bn++;
        end
        last_ack <= px_ack;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // mode: 0 quiet, 1 random pixel traffic, 2 held pixel request, 3 start pulses in FILL and DONE
    task automatic run(input logic [7:0] a0, input logic [7:0] a1, input logic [6:0] b0,
                       input logic [6:0] b1, input logic [23:0] c, input int mode, input int exp_n);
        int ea[$];
        int xe, ye, s, lim, nbad, nbc;
        fa.delete(); fd.delete(); fc.delete(); pc.delete(); dq.delete(); pq.delete();
        bn = 0;
        xe = (a1 > 159) ? 159 : int'(a1);
        ye = (b1 > 119) ? 119 : int'(b1);
        for (int y = int'(b0); y <= ye; y++)
            for (int x = int'(a0); x <= xe; x++)
                ea.push_back(y * 160 + x);
        tick;
        x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c; start = 1; rec = 1;
        s = cyc + 1;
        last_s = s;
        lim = ea.size() * 2 + 20;
        for (int i = 0; i < lim; i++) begin
            tick;
            start = 0; px_req = 0;
            x0 = 8'($urandom); x1 = 8'($urandom); y0 = 7'($urandom); y1 = 7'($urandom); color = 24'($urandom);
            if (mode == 1) begin
                px_req = 1'($urandom_range(0, 1)); px_addr = 15'($urandom); px_data = 24'($urandom);
            end
            if (mode == 2) begin
                px_req = (cyc >= s + 1) && (cyc <= s + 4); px_addr = 15'd500; px_data = 24'h00FF00;
            end
            if (mode == 3 && (cyc == s + 3 || (fc.size() == ea.size() && fc.size() > 0 && cyc == fc[$]))) begin
                start = 1; x0 = 100; x1 = 110; y0 = 50; y1 = 50;
            end
            if (dq.size() > 0 && cyc >= dq[0] + 4) break;
        end
        start = 0; px_req = 0;
        tick; tick;
        rec = 0;
        chk("done_pulses", dq.size(), 1);
        if (exp_n >= 0) chk("n_writes", fc.size(), exp_n);
        chk("n_writes_vs_model", fc.size(), ea.size());
        nbad = 0;
        for (int i = 0; i < fa.size() && i < ea.size(); i++)
            if (fa[i] != ea[i] || fd[i] !== c) begin
                if (nbad == 0) $display("first fill diff idx %0d: addr %0d/%0d data %h/%h", i, fa[i], ea[i], fd[i], c);
                nbad++;
            end
        chk("fill_seq_bad_entries", nbad, 0);
        if ((mode == 0 || mode == 3) && ea.size() > 0 && fc.size() > 0) begin
            chk("first_wr_latency", fc[0] - s, 2);
            nbc = 0;
            foreach (fc[i]) if (fc[i] != s + 2 + i) nbc++;
            chk("fill_consecutive", nbc, 0);
        end
        if (dq.size() > 0) begin
            chk("done_cycle", dq[0], (fc.size() > 0) ? fc[$] + 1 : s + 1);
            chk("busy_cycles", bn, dq[0] - s);
        end
        foreach (pq[i]) begin
            chk("px_ack", pq[i].ack, pq[i].exp);
            if (pq[i].ack) begin
                chk("px_wr_en", pq[i].en, 1);
                chk("px_wr_addr", pq[i].a, pq[i].ea);
                chk("px_wr_data", pq[i].d, pq[i].ed);
            end
        end
    endtask

    typedef struct {
        logic [7:0]  a0, a1;
        logic [6:0]  b0, b1;
        logic [23:0] c;
        int          n;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   offs[4];
        int   nbad;
        tbl[0] = '{8'd2,   8'd4,   7'd1,   7'd2,   24'hFF0000, 6};
        tbl[1] = '{8'd150, 8'd200, 7'd119, 7'd119, 24'h0000FF, 10};
        tbl[2] = '{8'd10,  8'd5,   7'd0,   7'd0,   24'h0F0F0F, 0};
        tbl[3] = '{8'd0,   8'd159, 7'd0,   7'd119, 24'h000000, 19200};
        tbl[4] = '{8'd159, 8'd255, 7'd119, 7'd127, 24'hABCDEF, 1};
        tbl[5] = '{8'd0,   8'd3,   7'd125, 7'd127, 24'h000001, 0};
        tbl[6] = '{8'd200, 8'd255, 7'd0,   7'd0,   24'h000002, 0};
        offs = '{3, 5, 6, 7};

        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_px_ack", px_ack, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 0;

        foreach (tbl[i]) run(tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, tbl[i].c, 0, tbl[i].n);

        for (int i = 0; i < 15; i++) begin
            int a0, b0;
            a0 = $urandom_range(0, 175);
            b0 = $urandom_range(0, 127);
            run(8'(a0), 8'(a0 - 3 + $urandom_range(0, 40)), 7'(b0), 7'(b0 - 2 + $urandom_range(0, 10)),
                24'($urandom), 1, -1);
        end

        run(8'd0, 8'd3, 7'd0, 7'd0, 24'h0000AA, 2, 4);
        chk("px_grants", pc.size(), 2);
        if (pc.size() == 2) begin
            chk("px_grant0_cycle", pc[0] - last_s, 2);
            chk("px_grant1_cycle", pc[1] - last_s, 4);
        end
        nbad = 0;
        for (int i = 0; i < 4 && i < fc.size(); i++) if (fc[i] - last_s != offs[i]) nbad++;
        chk("interleave_fill_cycles", nbad, 0);

        run(8'd0, 8'd7, 7'd2, 7'd2, 24'h777777, 3, 8);

        tick;
        x0 = 0; x1 = 159; y0 = 0; y1 = 119; color = 24'h123456; start = 1;
        tick;
        start = 0;
        repeat (500) tick;
        rst = 1;
        tick;
        chk("midrst_busy", busy, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_done", done, 0);
        rst = 0;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done || busy || wr_en) nbad++;
        end
        chk("midrst_quiet_after", nbad, 0);
        run(8'd5, 8'd6, 7'd3, 7'd3, 24'h456789, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
